// File: rtl/pt_fuse_loader.sv
// Product-term bitmap fuse loader: erases all PT select rows, or deserialises
// a fuse bitstream into one PTW-bit row per product term and writes it out.
module pt_fuse_loader #(
    parameter int NUM_PT = 80,
    parameter int PTW    = 96,
    parameter int AW     = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          bit_valid,
    input  logic          bit_in,
    output logic          bit_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [0:PTW-1] wr_data,
    output logic          busy,
    output logic          done
);

    localparam int BW = $clog2(PTW);
    localparam logic [AW-1:0] LAST_ROW = AW'(NUM_PT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PTW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   row, row_n;
    logic [BW-1:0]   bitcnt, bitcnt_n;
    logic [0:PTW-1]  shreg, shreg_n;
    logic            wr_en_n;
    logic [AW-1:0]   wr_addr_n;
    logic [0:PTW-1]  wr_data_n;

    assign bit_ready = (state == S_SHIFT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        row_n     = row;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    row_n    = '0;
                    bitcnt_n = '0;
                    if (mode) begin
                        state_n = S_SHIFT;
                    end else begin
                        state_n   = S_ERASE;
                        wr_en_n   = 1'b1;
                        wr_addr_n = '0;
                        wr_data_n = '0;
                    end
                end
            end
            S_ERASE: begin
                // Write strobes are registered, so the next row is set up a cycle ahead.
                if (row == LAST_ROW) begin
                    state_n = S_DONE;
                end else begin
                    row_n     = row + AW'(1);
                    wr_en_n   = 1'b1;
                    wr_addr_n = row + AW'(1);
                    wr_data_n = '0;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    shreg_n[bitcnt] = bit_in;
                    if (bitcnt == LAST_BIT) begin
                        state_n   = S_WRITE;
                        wr_en_n   = 1'b1;
                        wr_addr_n = row;
                        wr_data_n = shreg_n;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            S_WRITE: begin
                bitcnt_n = '0;
                if (row == LAST_ROW) begin
                    state_n = S_DONE;
                end else begin
                    row_n   = row + AW'(1);
                    state_n = S_SHIFT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values computed before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

endmodule

// File: doc/pt_fuse_loader.md
Name: pt_fuse_loader

Overview:
- Sequences configuration of the product-term select bitmaps (96-bit ptbitmap_mux rows) that feed the product-term AND-array inputs.
- Two operations: erase, which writes every row to all-zero so every PT evaluates to 0, and program, which accepts a serial fuse bitstream and writes one 96-bit row per product term into the PT bitmap storage.
- Sits between the fuse/JTAG front end and the PT bitmap register file of the macrocell array.

Parameters:
- NUM_PT, 80, number of product-term rows (16 macrocells x 5 PTs).
- PTW, 96, bits per row (16 FLB + 40 UIM true/complement pairs).
- AW, 7, row address width; must satisfy 2**AW >= NUM_PT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- mode  input  1  sampled with start: 0 = erase, 1 = program.
- bit_valid  input  1  serial fuse bit valid.
- bit_in  input  1  serial fuse bit.
- bit_ready  output  1  loader accepts bit_in this cycle.
- wr_en  output  1  row write strobe to PT bitmap storage.
- wr_addr  output  AW  row index being written.
- wr_data  output  [0:PTW-1]  row contents; index 0 = ptbitmap_mux[0].
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on operation completion.

Behaviour:
- Reset: synchronous. On rst=1 at a clk edge, the block enters IDLE and all outputs go to 0: bit_ready, wr_en, wr_addr, wr_data, busy, done. The shift register, bit counter and row counter are cleared. Reset mid-operation aborts with no further writes. Rows already written stay as written; no rollback.
- States: IDLE, ERASE, SHIFT, WRITE, DONE.
- IDLE:
  - start=1, mode=0 -> ERASE, row=0.
  - start=1, mode=1 -> SHIFT, row=0, bitcnt=0.
  - busy=0 only in IDLE.
- ERASE:
  - Each cycle: wr_en=1, wr_addr=row, wr_data=all-zero. All-zero row selects every literal and its complement, so the PT is forced to 0.
  - row increments each cycle.
  - After the write of row NUM_PT-1 -> DONE.
  - Duration: NUM_PT cycles.
- SHIFT:
  - bit_ready=1.
  - On bit_valid&bit_ready: the bit is stored at index bitcnt (first received bit -> index 0), then bitcnt increments.
  - When the bit at bitcnt=PTW-1 is accepted -> WRITE on the next edge.
  - bit_valid=0 stalls indefinitely; no timeout.
- WRITE:
  - Exactly one cycle: bit_ready=0, wr_en=1, wr_addr=row, wr_data=shift register.
  - Then bitcnt=0.
  - If row==NUM_PT-1 -> DONE; else row+1 -> SHIFT.
  - A bit offered during WRITE is not accepted and must be held by the source.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Output timing: wr_en, wr_addr and wr_data are registered and stable for the cycle wr_en=1. wr_data and wr_addr hold their last values while wr_en=0.
- Ignored inputs:
  - start outside IDLE has no effect.
  - bit_valid outside SHIFT has no effect.
  - mode is ignored except when start is sampled.
- Program latency: from start to done is NUM_PT*(PTW+1)+2 cycles with bit_valid held at 1. For NUM_PT=80 this is 7762 cycles.
- Counters never wrap. wr_addr never exceeds NUM_PT-1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0. Hold start=0 for 10 cycles -> busy stays 0 and wr_en never asserts.
- Erase: start=1, mode=0 -> wr_en=1 for exactly 80 consecutive cycles, wr_addr 0..79, wr_data=0 each cycle. done pulses 1 cycle after addr 79; busy drops the following cycle.
- Program, continuous: stream 80x96 bits, row r bit i = (i==r%96), with bit_valid=1 throughout -> 80 writes, row 5 has only bit 5 set. bit_ready=0 exactly on each write cycle; done at cycle 7762 after start.
- Program with stalls: pseudo-random bit_valid (≈50% duty), alternating-pattern rows -> same written data as the continuous case. No bit lost or duplicated; a bit offered during WRITE is taken in the following SHIFT cycle.
- Mid-operation reset: assert rst after 3 rows plus 40 bits -> next cycle in IDLE with wr_en=0 and busy=0. Only rows 0..2 were ever written. A new program run restarts at wr_addr=0 with bitcnt=0.
- Ignored start: start=1, mode=0 pulsed during SHIFT of a program run -> no erase writes occur and the program sequence completes unchanged.
